// File: rtl/lc3_pkg.sv
// Shared encodings for the LC-3 register-file write path.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package lc3_pkg;

   // DRMUX select values as seen by the register file
   localparam logic [1:0] DRMUX_DR = 2'b00;
   localparam logic [1:0] DRMUX_R7 = 2'b01;
   localparam logic [1:0] DRMUX_R6 = 2'b10;

   // Source tag of the beat currently on rf_*
   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_C    = 2'b01;
   localparam logic [1:0] GNT_I    = 2'b10;
   localparam logic [1:0] GNT_D    = 2'b11;

   // Arbiter FSM: IDLE arbitrates freely, LOCK reserves the port for an I burst
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

endpackage

// File: rtl/lc3_rr2_arbiter.sv
// Two-way round-robin picker between I and D; pointer starts at I.
// Latency: pick is combinational; pointer updates on the clock after advance.
// Backpressure: none; caller decides when a pick is consumed via advance.
module lc3_rr2_arbiter (
   input  logic clk,
   input  logic rst,
   input  logic req_i,
   input  logic req_d,
   input  logic advance,  // a grant to I or D happened this cycle
   input  logic winner,   // which one was granted: 0 = I, 1 = D
   output logic pick      // 0 = I wins, 1 = D wins
);

   logic ptr_q;  // 0 = I has priority, 1 = D has priority
   logic ptr_d;

   // A lone requester wins regardless of the pointer; otherwise the pointer decides
   always_comb begin
      pick  = req_d & (~req_i | ptr_q);
      ptr_d = ptr_q;
      if (advance) begin
         ptr_d = ~winner;
      end
   end

   // Pointer register, reset to favour I
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/lc3_rf_write_arbiter.sv
// Shares the LC-3 register-file write port between core (C), interrupt unit (I) and debug (D).
// Latency: beat accepted in cycle N is written (rf_we=1) in cycle N+1.
// Backpressure: one x_ready per cycle; C has priority but is stalled once I/D age out; I bursts lock the port.
module lc3_rf_write_arbiter
   import lc3_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        c_valid,
   input  logic [2:0]  c_dr,
   input  logic [1:0]  c_drmux,
   input  logic [15:0] c_data,
   output logic        c_ready,
   input  logic        i_valid,
   input  logic        i_last,
   input  logic [2:0]  i_dr,
   input  logic [1:0]  i_drmux,
   input  logic [15:0] i_data,
   output logic        i_ready,
   input  logic        d_valid,
   input  logic [2:0]  d_dr,
   input  logic [15:0] d_data,
   output logic        d_ready,
   output logic        rf_we,
   output logic [2:0]  rf_dr,
   output logic [1:0]  rf_drmux,
   output logic [15:0] rf_d,
   output logic [1:0]  grant_id,
   output logic        lock
);

   localparam logic [3:0] AGE_MAX = 4'(MAX_WAIT);

   state_t      state_q, state_d;
   logic [3:0]  age_q, age_d;
   logic        rf_we_q, rf_we_d;
   logic [2:0]  rf_dr_q, rf_dr_d;
   logic [1:0]  rf_drmux_q, rf_drmux_d;
   logic [15:0] rf_d_q, rf_d_d;
   logic [1:0]  grant_id_q, grant_id_d;

   logic gnt_c, gnt_i, gnt_d;
   logic any_id;
   logic rr_pick;

   lc3_rr2_arbiter u_rr (
      .clk     (clk),
      .rst     (rst),
      .req_i   (i_valid),
      .req_d   (d_valid),
      .advance (gnt_i | gnt_d),
      .winner  (gnt_d),
      .pick    (rr_pick)
   );

   // Grant selection: LOCK serves only I; IDLE lets aged I/D pre-empt C, else C first, else round robin
   always_comb begin
      gnt_c  = 1'b0;
      gnt_i  = 1'b0;
      gnt_d  = 1'b0;
      any_id = i_valid | d_valid;
      if (state_q == ST_LOCK) begin
         gnt_i = i_valid;
      end else if ((age_q == AGE_MAX) && any_id) begin
         gnt_i = ~rr_pick;
         gnt_d = rr_pick;
      end else if (c_valid) begin
         gnt_c = 1'b1;
      end else if (any_id) begin
         gnt_i = ~rr_pick;
         gnt_d = rr_pick;
      end
   end

   assign c_ready = gnt_c;
   assign i_ready = gnt_i;
   assign d_ready = gnt_d;

   // Next state for FSM, age counter and the registered write-port image
   always_comb begin
      state_d    = state_q;
      age_d      = age_q;
      rf_we_d    = gnt_c | gnt_i | gnt_d;
      rf_dr_d    = rf_dr_q;
      rf_drmux_d = rf_drmux_q;
      rf_d_d     = rf_d_q;
      grant_id_d = GNT_NONE;

      if (state_q == ST_IDLE) begin
         if (gnt_i && !i_last) begin
            state_d = ST_LOCK;
         end
         // Age counts C wins over a waiting I/D; frozen while locked
         if (gnt_i || gnt_d || !any_id) begin
            age_d = 4'd0;
         end else if (gnt_c && (age_q != AGE_MAX)) begin
            age_d = age_q + 4'd1;
         end
      end else if (gnt_i && i_last) begin
         state_d = ST_IDLE;
      end

      if (gnt_c) begin
         rf_dr_d    = c_dr;
         rf_drmux_d = c_drmux;
         rf_d_d     = c_data;
         grant_id_d = GNT_C;
      end else if (gnt_i) begin
         rf_dr_d    = i_dr;
         rf_drmux_d = i_drmux;
         rf_d_d     = i_data;
         grant_id_d = GNT_I;
      end else if (gnt_d) begin
         rf_dr_d    = d_dr;
         rf_drmux_d = DRMUX_DR;
         rf_d_d     = d_data;
         grant_id_d = GNT_D;
      end
   end

   // FSM and output registers; reset aborts any burst and kills a pending write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         age_q      <= 4'd0;
         rf_we_q    <= 1'b0;
         rf_dr_q    <= 3'd0;
         rf_drmux_q <= 2'd0;
         rf_d_q     <= 16'd0;
         grant_id_q <= GNT_NONE;
      end else begin
         state_q    <= state_d;
         age_q      <= age_d;
         rf_we_q    <= rf_we_d;
         rf_dr_q    <= rf_dr_d;
         rf_drmux_q <= rf_drmux_d;
         rf_d_q     <= rf_d_d;
         grant_id_q <= grant_id_d;
      end
   end

   assign rf_we    = rf_we_q;
   assign rf_dr    = rf_dr_q;
   assign rf_drmux = rf_drmux_q;
   assign rf_d     = rf_d_q;
   assign grant_id = grant_id_q;
   assign lock     = (state_q == ST_LOCK);

endmodule

// File: tb/tb_lc3_rf_write_arbiter.sv
// Self-checking bench for lc3_rf_write_arbiter (MAX_WAIT = 4).
// Each step is one clock: readies/lock checked against scripted values, writes via scoreboard.
// Expected writes are queued when a beat is expected to be accepted and popped one cycle later.
module tb_lc3_rf_write_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        c_valid = 1'b0;
   logic [2:0]  c_dr = 3'd0;
   logic [1:0]  c_drmux = 2'd0;
   logic [15:0] c_data = 16'd0;
   logic        c_ready;
   logic        i_valid = 1'b0;
   logic        i_last = 1'b0;
   logic [2:0]  i_dr = 3'd0;
   logic [1:0]  i_drmux = 2'd0;
   logic [15:0] i_data = 16'd0;
   logic        i_ready;
   logic        d_valid = 1'b0;
   logic [2:0]  d_dr = 3'd0;
   logic [15:0] d_data = 16'd0;
   logic        d_ready;
   logic        rf_we;
   logic [2:0]  rf_dr;
   logic [1:0]  rf_drmux;
   logic [15:0] rf_d;
   logic [1:0]  grant_id;
   logic        lock;

   int n_pass = 0;
   int n_chk  = 0;

   // {dr, drmux, data, grant_id}
   logic [22:0] sb[$];

   always #5 clk = ~clk;

   lc3_rf_write_arbiter #(.MAX_WAIT(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .c_valid  (c_valid),
      .c_dr     (c_dr),
      .c_drmux  (c_drmux),
      .c_data   (c_data),
      .c_ready  (c_ready),
      .i_valid  (i_valid),
      .i_last   (i_last),
      .i_dr     (i_dr),
      .i_drmux  (i_drmux),
      .i_data   (i_data),
      .i_ready  (i_ready),
      .d_valid  (d_valid),
      .d_dr     (d_dr),
      .d_data   (d_data),
      .d_ready  (d_ready),
      .rf_we    (rf_we),
      .rf_dr    (rf_dr),
      .rf_drmux (rf_drmux),
      .rf_d     (rf_d),
      .grant_id (grant_id),
      .lock     (lock)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One cycle: check last cycle's write, check readies/lock, queue expected write
   task automatic step(input logic ec, input logic ei, input logic ed, input logic el);
      logic [22:0] e;
      @(negedge clk);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("write", {8'b0, rf_we, rf_dr, rf_drmux, rf_d, grant_id}, {8'b0, 1'b1, e});
      end else begin
         chk("no_write", {29'b0, rf_we, grant_id}, 32'd0);
      end
      chk("rdy_c_i_d_lock", {28'b0, c_ready, i_ready, d_ready, lock}, {28'b0, ec, ei, ed, el});
      if (ec) sb.push_back({c_dr, c_drmux, c_data, 2'b01});
      if (ei) sb.push_back({i_dr, i_drmux, i_data, 2'b10});
      if (ed) sb.push_back({d_dr, 2'b00, d_data, 2'b11});
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out", {7'b0, rf_we, rf_dr, rf_drmux, rf_d, grant_id, lock}, 32'd0);
      rst = 1'b0;

      // Basic C write and hold of payload when idle
      c_valid = 1'b1; c_dr = 3'd3; c_drmux = 2'b00; c_data = 16'h1234;
      step(1, 0, 0, 0);
      c_valid = 1'b0;
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("hold_payload", {13'b0, rf_dr, rf_d}, {13'b0, 3'd3, 16'h1234});

      // Starvation: C continuous, D waits MAX_WAIT C grants, twice to show age restarts
      c_valid = 1'b1; c_dr = 3'd1; c_drmux = 2'b00; c_data = 16'h0100;
      d_valid = 1'b1; d_dr = 3'd5; d_data = 16'hBEEF;
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 4; k++) begin
            step(1, 0, 0, 0);
            c_data = c_data + 16'd1;
         end
         step(0, 0, 1, 0);
         d_data = d_data + 16'd1;
      end
      c_valid = 1'b0; d_valid = 1'b0;
      step(0, 0, 0, 0);

      // Round robin I/D alternation; pointer at I after the last D grant; reserved drmux passes
      i_valid = 1'b1; i_last = 1'b1; i_dr = 3'd2; i_drmux = 2'b11; i_data = 16'hA000;
      d_valid = 1'b1; d_dr = 3'd4; d_data = 16'hD000;
      for (int k = 0; k < 2; k++) begin
         step(0, 1, 0, 0);
         i_data = i_data + 16'd1;
         step(0, 0, 1, 0);
         d_data = d_data + 16'd1;
      end
      i_valid = 1'b0; d_valid = 1'b0;
      step(0, 0, 0, 0);

      // Burst with C and D pending: C until I/D age out, then R6/R7 back-to-back under lock
      c_valid = 1'b1; c_dr = 3'd6; c_drmux = 2'b00; c_data = 16'h5555;
      d_valid = 1'b1; d_dr = 3'd7; d_data = 16'h7777;
      i_valid = 1'b1; i_last = 1'b0; i_dr = 3'd0; i_drmux = 2'b10; i_data = 16'hFE00;
      repeat (4) step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      i_last = 1'b1; i_drmux = 2'b01; i_data = 16'h3001;
      step(0, 1, 0, 1);
      i_valid = 1'b0;
      step(1, 0, 0, 0);
      c_valid = 1'b0;
      step(0, 0, 1, 0);
      d_valid = 1'b0;
      step(0, 0, 0, 0);

      // Mid-burst gap: lock holds, C stalled, no writes
      i_valid = 1'b1; i_last = 1'b0; i_drmux = 2'b10; i_data = 16'hFE10;
      step(0, 1, 0, 0);
      i_valid = 1'b0;
      c_valid = 1'b1; c_dr = 3'd1; c_data = 16'h0C0C;
      repeat (3) step(0, 0, 0, 1);
      i_valid = 1'b1; i_last = 1'b1; i_drmux = 2'b01; i_data = 16'h3011;
      step(0, 1, 0, 1);
      i_valid = 1'b0;
      step(1, 0, 0, 0);
      c_valid = 1'b0;
      step(0, 0, 0, 0);

      // Reset during lock right after a beat was accepted: write and lock vanish at once
      i_valid = 1'b1; i_last = 1'b0; i_drmux = 2'b10; i_data = 16'hFE20;
      step(0, 1, 0, 0);
      i_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_mid_burst", {28'b0, rf_we, lock, grant_id}, 32'd0);
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      c_valid = 1'b1; c_dr = 3'd2; c_drmux = 2'b00; c_data = 16'h2222;
      step(1, 0, 0, 0);
      c_valid = 1'b0;
      // Pointer back at I after reset
      i_valid = 1'b1; i_last = 1'b1; i_dr = 3'd3; i_drmux = 2'b00; i_data = 16'h4444;
      d_valid = 1'b1; d_dr = 3'd6; d_data = 16'h6666;
      step(0, 1, 0, 0);
      i_valid = 1'b0;
      step(0, 0, 1, 0);
      d_valid = 1'b0;
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/lc3_rf_write_arbiter.md
Name: lc3_rf_write_arbiter

Overview:
- Owns the single write port of the LC-3 register file and shares it between three requesters: core writeback (C), interrupt/trap save unit (I) and debug host loader (D).
- C has priority, but an aging counter stops I and D from starving.
- I may issue atomic multi-beat bursts, such as the R6 then R7 save on interrupt entry.
- Outputs are registered and drive the register file's we, DR, DRMUX and d inputs directly.

Parameters:
- MAX_WAIT, 4, number of consecutive cycles a pending I/D request may be blocked by C before C is forcibly stalled (range 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- c_valid  in  1  core writeback request
- c_dr  in  3  core destination register (IR[11:9])
- c_drmux  in  2  core DRMUX select (00 = DR, 01 = R7, 10 = R6)
- c_data  in  16  core write data
- c_ready  out  1  core beat accepted this cycle
- i_valid  in  1  interrupt unit request
- i_last  in  1  final beat of an I burst
- i_dr  in  3  I destination register
- i_drmux  in  2  I DRMUX select
- i_data  in  16  I write data
- i_ready  out  1  I beat accepted
- d_valid  in  1  debug request
- d_dr  in  3  debug destination register (DRMUX forced to 00)
- d_data  in  16  debug write data
- d_ready  out  1  debug beat accepted
- rf_we  out  1  register file write enable
- rf_dr  out  3  to register file DR
- rf_drmux  out  2  to register file DRMUX select
- rf_d  out  16  to register file d
- grant_id  out  2  source of the current rf_* beat: 00 none, 01 C, 10 I, 11 D
- lock  out  1  I burst in progress

Behaviour:
- Handshake: a beat transfers when x_valid and x_ready are both 1. Each x_ready is combinational from state and the valids. At most one x_ready is high per cycle. A requester holds valid and payload stable until the beat is accepted, and must not make valid depend on ready.
- Latency: a beat accepted in cycle N appears on rf_* with rf_we=1 in cycle N+1, for exactly one cycle. With no transfer in cycle N, cycle N+1 has rf_we=0 and grant_id=00. rf_dr, rf_drmux and rf_d hold their last values when rf_we=0.
- Reset: all outputs 0, state IDLE, age counter 0, rr pointer = I.
- FSM state IDLE, arbitration order:
  1. If age == MAX_WAIT and (i_valid or d_valid), grant the rr winner and hold c_ready=0.
  2. Otherwise, if c_valid, grant C.
  3. Otherwise grant the rr winner among valid I/D. If only one is valid, it wins regardless of the pointer.
- Round robin: after an I grant the pointer moves to D; after a D grant it moves to I. The pointer is unchanged by C grants.
- Aging:
  - Counter increments (saturating at MAX_WAIT) in any cycle where C is granted while i_valid or d_valid is high.
  - Counter clears on any I or D grant, and when i_valid and d_valid are both 0.
- Lock entry: IDLE -> LOCK when an I beat is accepted with i_last=0. lock=1 from the following cycle.
- FSM state LOCK:
  - Only I may be granted; c_ready=0 and d_ready=0.
  - The age counter freezes.
  - If i_valid drops mid-burst, LOCK holds with no writes.
  - An I beat with i_last=1 returns the FSM to IDLE the next cycle and moves the rr pointer to D.
- A single-beat I request (i_last=1 in IDLE) never enters LOCK.
- Payload is passed through unchanged, including the reserved drmux value 11. D beats always output rf_drmux=00.
- Reset asserted mid-burst aborts the lock immediately. A beat accepted in the cycle before reset does not write: rf_we is cleared asynchronously.

Decomposition:
- Shared package lc3_pkg:
  - DRMUX encodings: DRMUX_DR=2'b00, DRMUX_R7=2'b01, DRMUX_R6=2'b10.
  - grant_id encodings: GNT_NONE/C/I/D.
  - FSM state encodings: ST_IDLE/ST_LOCK.
- Sub-module lc3_rr2_arbiter: 2-way round-robin picker holding the pointer, with inputs req_i, req_d, advance and winner.

Test Plan:
- Reset, then C writes: c_valid, c_dr=3, c_data=16'h1234 -> c_ready=1 the same cycle; next cycle rf_we=1, rf_dr=3, rf_drmux=00, rf_d=16'h1234, grant_id=01.
- Starvation with MAX_WAIT=4: c_valid held high continuously, d_valid, d_dr=5 -> C granted 4 cycles, 5th cycle d_ready=1 and c_ready=0; next cycle rf_dr=5, grant_id=11; age returns to 0.
- Round robin: i_valid and d_valid both held, i_last=1, c_valid=0 -> grants alternate I, D, I, D starting with I after reset.
- Burst: I beats (drmux 10, 16'hFE00, last=0) then (drmux 01, 16'h3001, last=1) with c_valid and d_valid high throughout -> rf writes R6=FE00 then R7=3001 back-to-back; lock=1 between the two beats; C and D are blocked until after the last beat.
- Mid-burst gap: first I beat accepted, i_valid low for 3 cycles -> lock stays 1, rf_we=0, c_ready=0; the last beat then completes and lock clears.
- Reset during LOCK -> lock=0, rf_we=0, grant_id=00 immediately; the next c_valid is granted in the first cycle after reset deasserts.
